// File: rtl/wb_dma_copy.sv
// rtl/wb_dma_copy.sv - Wishbone pipelined word-copy DMA engine
//
// Purpose: copies LEN 32-bit words from SRC to DST, one read and then one
// write per word, as a Wishbone pipelined initiator. It is programmed
// through a small Wishbone pipelined responder.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wbs_*                       register responder: 0=SRC 1=DST 2=LEN 3=CTRL/STATUS
//   wbm_*                       copy initiator, one transaction per cyc
//   irq                         level interrupt, mirrors STATUS.done
module wb_dma_copy #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wbs_adr,
  input  logic [31:0] wbs_dat_w,
  output logic [31:0] wbs_dat_r,
  input  logic [3:0]  wbs_sel,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  output logic        wbs_ack,
  output logic        wbs_stall,
  output logic        wbs_err,
  output logic [31:0] wbm_adr,
  output logic [31:0] wbm_dat_w,
  input  logic [31:0] wbm_dat_r,
  output logic [3:0]  wbm_sel,
  output logic        wbm_we,
  output logic        wbm_cyc,
  output logic        wbm_stb,
  input  logic        wbm_stall,
  input  logic        wbm_ack,
  input  logic        wbm_err,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_W, S_WR, S_WR_W, S_FIN
  } state_t;

  state_t           r_state;
  logic [31:0]      r_src, r_dst, r_wsrc, r_wdst, r_data, r_adr, r_dat_r;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic             r_busy, r_done, r_err, r_go, r_ack;
  logic             r_cyc, r_stb, r_we;

  logic             w_req, w_wr, w_start, w_clr;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Byte selects are irrelevant: every register access is a full word.
  assign w_unused = ^wbs_sel;

  assign w_req   = wbs_cyc & wbs_stb;
  assign w_wr    = w_req & wbs_we;
  assign w_start = w_wr && (wbs_adr == 2'd3) && wbs_dat_w[0] && !r_busy;
  assign w_clr   = w_wr && (wbs_adr == 2'd3) && wbs_dat_w[1];

  always_comb begin
    w_rdata = 32'd0;
    case (wbs_adr)
      2'd0:    w_rdata = r_src;
      2'd1:    w_rdata = r_dst;
      2'd2:    w_rdata = 32'(r_len);
      default: w_rdata = {29'd0, r_err, r_done, r_busy};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_wsrc  <= '0;
      r_wdst  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_adr   <= '0;
      r_dat_r <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_go    <= 1'b0;
      r_ack   <= 1'b0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      // Responder: registered ack one cycle after each request.
      r_ack <= w_req;
      if (w_req && !wbs_we) r_dat_r <= w_rdata;

      if (w_wr && !r_busy) begin
        case (wbs_adr)
          2'd0:    r_src <= {wbs_dat_w[31:2], 2'b00};
          2'd1:    r_dst <= {wbs_dat_w[31:2], 2'b00};
          2'd2:    r_len <= wbs_dat_w[LEN_W-1:0];
          default: ;
        endcase
      end

      if (w_start) begin
        r_wsrc <= r_src;
        r_wdst <= r_dst;
        r_cnt  <= r_len;
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_busy <= 1'b1;
        r_go   <= 1'b1;
      end else if (w_clr) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end

      // Each bus phase spends one cycle with cyc low before raising cyc/stb,
      // which gives the mandatory gap between a word's read and its write.
      case (r_state)
        S_IDLE: begin
          if (r_go) begin
            r_go    <= 1'b0;
            r_state <= (r_cnt == '0) ? S_FIN : S_RD;
          end
        end
        S_RD: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= 1'b0;
            r_adr <= r_wsrc;
          end else if (!wbm_stall) begin
            r_stb   <= 1'b0;
            r_state <= S_RD_W;
          end
        end
        S_RD_W: begin
          if (wbm_err) begin
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_state <= S_FIN;
          end else if (wbm_ack) begin
            r_data  <= wbm_dat_r;
            r_cyc   <= 1'b0;
            r_state <= S_WR;
          end
        end
        S_WR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= r_wdst;
          end else if (!wbm_stall) begin
            r_stb   <= 1'b0;
            r_state <= S_WR_W;
          end
        end
        S_WR_W: begin
          if (wbm_err) begin
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= S_FIN;
          end else if (wbm_ack) begin
            r_wsrc  <= r_wsrc + 32'd4;
            r_wdst  <= r_wdst + 32'd4;
            r_cnt   <= r_cnt - LEN_W'(1);
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= (r_cnt == LEN_W'(1)) ? S_FIN : S_RD;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbs_dat_r = r_dat_r;
  assign wbs_ack   = r_ack;
  assign wbs_stall = 1'b0;
  assign wbs_err   = 1'b0;
  assign wbm_adr   = r_adr;
  assign wbm_dat_w = r_data;
  assign wbm_sel   = {4{r_cyc}};
  assign wbm_we    = r_we;
  assign wbm_cyc   = r_cyc;
  assign wbm_stb   = r_stb;
  assign irq       = r_done;

endmodule

// File: tb/tb_wb_dma_copy.sv
// tb/tb_wb_dma_copy.sv - self-checking bench for wb_dma_copy
module tb_wb_dma_copy;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wbs_adr = '0;
  logic [31:0] wbs_dat_w = '0;
  logic [31:0] wbs_dat_r;
  logic [3:0]  wbs_sel = 4'hF;
  logic        wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
  logic        wbs_ack, wbs_stall, wbs_err;
  logic [31:0] wbm_adr, wbm_dat_w;
  logic [31:0] wbm_dat_r;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb;
  logic        wbm_stall, wbm_ack, wbm_err;
  logic        irq;

  wb_dma_copy #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_adr(wbs_adr), .wbs_dat_w(wbs_dat_w), .wbs_dat_r(wbs_dat_r), .wbs_sel(wbs_sel),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
    .wbs_ack(wbs_ack), .wbs_stall(wbs_stall), .wbs_err(wbs_err),
    .wbm_adr(wbm_adr), .wbm_dat_w(wbm_dat_w), .wbm_dat_r(wbm_dat_r), .wbm_sel(wbm_sel),
    .wbm_we(wbm_we), .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb),
    .wbm_stall(wbm_stall), .wbm_ack(wbm_ack), .wbm_err(wbm_err), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  initial forever begin
    @(posedge clk);
    cyc_cnt = cyc_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Memory model: unwritten words hold a fixed pattern of their address.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  // Expected initiator transactions, in order.
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;
  txn_t exp_q[$];

  task automatic push_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    txn_t t;
    t.we = we; t.adr = adr; t.dat = dat;
    exp_q.push_back(t);
  endtask

  // A copy reads word i then writes it; a read error on word err_word ends it.
  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input int err_word);
    for (int i = 0; i < len; i++) begin
      push_txn(1'b0, src + 32'(4 * i), 32'd0);
      if (err_word == i + 1) break;
      push_txn(1'b1, dst + 32'(4 * i), pat(src + 32'(4 * i)));
    end
  endtask

  task automatic check_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    for (int i = 0; i < len; i++)
      chk("dst_data", memrd(dst + 32'(4 * i)), pat(src + 32'(4 * i)));
  endtask

  // Responder model: optional random stall, 0-5 wait states, error injection.
  bit rnd_mode    = 1'b0;
  bit resp_flush  = 1'b0;
  int err_at_read = 0;
  int rd_count    = 0;

  initial begin
    bit          pend = 1'b0;
    bit          pend_err = 1'b0;
    int          pend_wait = 0;
    logic [31:0] pend_dat = '0;
    wbm_stall = 1'b0; wbm_ack = 1'b0; wbm_err = 1'b0; wbm_dat_r = '0;
    forever begin
      @(posedge clk);
      #2;
      wbm_ack = 1'b0;
      wbm_err = 1'b0;
      if (resp_flush) begin
        pend = 1'b0;
        resp_flush = 1'b0;
      end
      if (pend) begin
        if (pend_wait == 0) begin
          if (pend_err) wbm_err = 1'b1;
          else wbm_ack = 1'b1;
          wbm_dat_r = pend_dat;
          pend = 1'b0;
        end else begin
          pend_wait--;
        end
      end
      wbm_stall = rnd_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (rst_n && wbm_cyc && wbm_stb && !wbm_stall) begin
        pend      = 1'b1;
        pend_wait = rnd_mode ? int'($urandom_range(0, 5)) : 0;
        pend_err  = 1'b0;
        pend_dat  = '0;
        if (wbm_we) begin
          mem[wbm_adr] = wbm_dat_w;
        end else begin
          rd_count++;
          if (err_at_read != 0 && rd_count == err_at_read) pend_err = 1'b1;
          else pend_dat = memrd(wbm_adr);
        end
      end
    end
  end

  // Compare process: bus discipline and every accepted transaction.
  initial begin
    bit          outst = 1'b0;
    bit          prev_stall_stb = 1'b0;
    bit          prev_rd_ack = 1'b0;
    logic [31:0] prev_adr = '0;
    txn_t        t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outst = 1'b0; prev_stall_stb = 1'b0; prev_rd_ack = 1'b0;
        continue;
      end
      if (prev_rd_ack) chk("cyc_gap", 32'(wbm_cyc), 32'd0);
      if (prev_stall_stb) begin
        chk("stb_held", 32'(wbm_stb), 32'd1);
        chk("adr_stable", wbm_adr, prev_adr);
      end
      if (wbm_stb) chk("stb_cyc", 32'(wbm_cyc), 32'd1);
      if (wbm_ack || wbm_err) outst = 1'b0;
      if (wbm_cyc && wbm_stb && !wbm_stall) begin
        chk("one_outstanding", 32'(outst), 32'd0);
        outst = 1'b1;
        chk("sel", 32'(wbm_sel), 32'hF);
        chk("txn_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          chk("txn_we", 32'(wbm_we), 32'(t.we));
          chk("txn_adr", wbm_adr, t.adr);
          if (t.we) chk("txn_dat", wbm_dat_w, t.dat);
        end
      end
      prev_rd_ack    = wbm_cyc && wbm_ack && !wbm_we;
      prev_stall_stb = wbm_stb && wbm_stall;
      prev_adr       = wbm_adr;
    end
  end

  // Register access; called and returns on a falling edge.
  task automatic wbs_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] q);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_adr = a; wbs_dat_w = d;
    @(negedge clk);
    chk("wbs_ack", 32'(wbs_ack), 32'd1);
    q = wbs_dat_r;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    @(negedge clk);
    chk("wbs_ack_pulse", 32'(wbs_ack), 32'd0);
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    wbs_xfer(1'b1, a, d, q);
  endtask

  task automatic reg_chk(input logic [1:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] q;
    wbs_xfer(1'b0, a, 32'd0, q);
    chk(nm, q, exp);
  endtask

  task automatic wait_irq(input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (irq) break;
      @(negedge clk);
    end
    chk(nm, 32'(irq), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("no_bus_activity", 32'(wbm_cyc), 32'd0);
    end
  endtask

  initial begin
    int t0, t1;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(wbm_cyc), 32'd0);
    chk("rst_stb", 32'(wbm_stb), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_wbs_ack", 32'(wbs_ack), 32'd0);
    chk("rst_adr", wbm_adr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    reg_chk(2'd3, 32'd0, "rst_status");
    reg_chk(2'd0, 32'd0, "rst_src");

    // Register map behaviour
    reg_wr(2'd0, 32'h0000_0103);
    reg_chk(2'd0, 32'h0000_0100, "src_align");
    reg_wr(2'd1, 32'hABCD_0007);
    reg_chk(2'd1, 32'hABCD_0004, "dst_align");
    reg_wr(2'd2, 32'hFFFF_1234);
    reg_chk(2'd2, 32'h0000_1234, "len_zext");

    // Zero-wait copy of 4 words: 24 cycles from first cyc to done
    reg_wr(2'd0, 32'h100);
    reg_wr(2'd1, 32'h200);
    reg_wr(2'd2, 32'd4);
    push_copy(32'h100, 32'h200, 4, 0);
    reg_wr(2'd3, 32'd1);
    t0 = 0;
    for (int i = 0; i < 50; i++) begin
      if (wbm_cyc) break;
      @(negedge clk);
    end
    t0 = cyc_cnt;
    wait_irq(200, "copy4_done");
    t1 = cyc_cnt;
    chk("copy4_cycles", 32'(t1 - t0), 32'd24);
    reg_chk(2'd3, 32'h2, "copy4_status");
    chk("copy4_queue", 32'(exp_q.size()), 32'd0);
    check_copy(32'h100, 32'h200, 4);

    // Random stall and wait states
    rnd_mode = 1'b1;
    reg_wr(2'd0, 32'h1000);
    reg_wr(2'd1, 32'h2000);
    reg_wr(2'd2, 32'd5);
    push_copy(32'h1000, 32'h2000, 5, 0);
    reg_wr(2'd3, 32'd1);
    wait_irq(2000, "rnd_done");
    reg_chk(2'd3, 32'h2, "rnd_status");
    chk("rnd_queue", 32'(exp_q.size()), 32'd0);
    check_copy(32'h1000, 32'h2000, 5);
    rnd_mode = 1'b0;

    // LEN=0: no bus activity, done two cycles after the start ack
    reg_wr(2'd2, 32'd0);
    reg_wr(2'd3, 32'd1);
    chk("len0_irq_early", 32'(irq), 32'd0);
    chk("len0_no_cyc", 32'(wbm_cyc), 32'd0);
    @(negedge clk);
    chk("len0_irq", 32'(irq), 32'd1);
    reg_chk(2'd3, 32'h2, "len0_status");
    reg_wr(2'd3, 32'd2);
    chk("clr_irq", 32'(irq), 32'd0);
    reg_chk(2'd3, 32'h0, "clr_status");

    // Error on the third read of eight
    err_at_read = 3;
    rd_count = 0;
    reg_wr(2'd0, 32'h8000);
    reg_wr(2'd1, 32'h9000);
    reg_wr(2'd2, 32'd8);
    push_copy(32'h8000, 32'h9000, 8, 3);
    reg_wr(2'd3, 32'd1);
    wait_irq(300, "err_done");
    reg_chk(2'd3, 32'h6, "err_status");
    idle_cycles(10);
    chk("err_queue", 32'(exp_q.size()), 32'd0);
    check_copy(32'h8000, 32'h9000, 2);
    chk("err_word3_unwritten", 32'(mem.exists(32'h9008)), 32'd0);
    err_at_read = 0;

    // Address wrap past 2^32
    reg_wr(2'd0, 32'hFFFF_FFF8);
    reg_wr(2'd1, 32'h3000);
    reg_wr(2'd2, 32'd3);
    push_txn(1'b0, 32'hFFFF_FFF8, 32'd0);
    push_txn(1'b1, 32'h0000_3000, pat(32'hFFFF_FFF8));
    push_txn(1'b0, 32'hFFFF_FFFC, 32'd0);
    push_txn(1'b1, 32'h0000_3004, pat(32'hFFFF_FFFC));
    push_txn(1'b0, 32'h0000_0000, 32'd0);
    push_txn(1'b1, 32'h0000_3008, pat(32'h0000_0000));
    reg_wr(2'd3, 32'd1);
    wait_irq(200, "wrap_done");
    reg_chk(2'd3, 32'h2, "wrap_status");
    chk("wrap_queue", 32'(exp_q.size()), 32'd0);

    // Writes and start while busy are ignored
    rnd_mode = 1'b1;
    reg_wr(2'd0, 32'h4000);
    reg_wr(2'd1, 32'h5000);
    reg_wr(2'd2, 32'd6);
    push_copy(32'h4000, 32'h5000, 6, 0);
    reg_wr(2'd3, 32'd1);
    reg_wr(2'd1, 32'h6000);
    reg_wr(2'd3, 32'd1);
    reg_chk(2'd3, 32'h1, "busy_status");
    reg_chk(2'd1, 32'h5000, "busy_dst_kept");
    wait_irq(3000, "busy_done");
    reg_chk(2'd3, 32'h2, "busy_final_status");
    chk("busy_queue", 32'(exp_q.size()), 32'd0);
    check_copy(32'h4000, 32'h5000, 6);
    rnd_mode = 1'b0;

    // Reset during the first write wait: cyc falls at once
    reg_wr(2'd1, 32'h7000);
    reg_wr(2'd2, 32'd2);
    push_copy(32'h4000, 32'h7000, 2, 0);
    reg_wr(2'd3, 32'd1);
    for (int i = 0; i < 100; i++) begin
      if (wbm_cyc && wbm_stb && wbm_we && !wbm_stall) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("wrw_cyc", 32'(wbm_cyc), 32'd1);
    rst_n = 1'b0;
    resp_flush = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_cyc", 32'(wbm_cyc), 32'd0);
    chk("rst_mid_stb", 32'(wbm_stb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_irq", 32'(irq), 32'd0);
    reg_chk(2'd3, 32'h0, "post_rst_status");
    idle_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
